// File: rtl/blk_pos_counter.sv
// Block-position generator: walks BLK_SIZE sub-blocks through each MB_SIZE macroblock,
// macroblocks in raster order across the frame, with skip/back commands and done pulses.
module blk_pos_counter #(
  parameter int unsigned FRAME_W  = 352,
  parameter int unsigned FRAME_H  = 288,
  parameter int unsigned MB_SIZE  = 16,
  parameter int unsigned BLK_SIZE = 4,
  parameter int unsigned CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  input  logic          mb_next,
  input  logic          mb_back,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [CW-1:0] mb_x,
  output logic [CW-1:0] mb_y,
  output logic [7:0]    blk_idx,
  output logic          busy,
  output logic          mb_done,
  output logic          frame_done
);

  localparam int unsigned N    = MB_SIZE / BLK_SIZE;
  localparam int unsigned MBW  = FRAME_W / MB_SIZE;
  localparam int unsigned MBH  = FRAME_H / MB_SIZE;
  localparam int unsigned NBLK = N * N;

  localparam logic [CW-1:0] MBW_M1 = CW'(MBW - 1);
  localparam logic [CW-1:0] MBH_M1 = CW'(MBH - 1);
  localparam logic [CW-1:0] MB_SZ  = CW'(MB_SIZE);
  localparam logic [CW-1:0] BLK_SZ = CW'(BLK_SIZE);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [7:0]    NB     = 8'(N);
  localparam logic [7:0]    BLK_M1 = 8'(NBLK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] mbx_q, mby_q, mbx_d, mby_d;
  logic [CW-1:0] x_q, y_q, x_d, y_d;
  logic [7:0]    blk_q, blk_d;
  logic          mbd_q, fd_q, mbd_d, fd_d;
  logic          leave;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mbx_q   <= '0;
      mby_q   <= '0;
      blk_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mbd_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mbx_q   <= mbx_d;
      mby_q   <= mby_d;
      blk_q   <= blk_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mbd_q   <= mbd_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mbx_d   = mbx_q;
    mby_d   = mby_q;
    blk_d   = blk_q;
    mbd_d   = 1'b0;
    fd_d    = 1'b0;
    leave   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mbx_d   = '0;
          mby_d   = '0;
          blk_d   = '0;
        end
      end
      RUN: begin
        // mb_back wins outright; at column 0 it still swallows any step/mb_next
        if (mb_back) begin
          if (mbx_q != '0) begin
            mbx_d = mbx_q - ONE;
            blk_d = '0;
          end
        end else if (mb_next) begin
          leave = 1'b1;
        end else if (step) begin
          if (blk_q < BLK_M1) blk_d = blk_q + 8'd1;
          else                leave = 1'b1;
        end
        if (leave) begin
          blk_d = '0;
          mbd_d = 1'b1;
          if (mbx_q < MBW_M1) begin
            mbx_d = mbx_q + ONE;
          end else if (mby_q < MBH_M1) begin
            mbx_d = '0;
            mby_d = mby_q + ONE;
          end else begin
            mbx_d   = '0;
            mby_d   = '0;
            fd_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    x_d = mbx_d * MB_SZ + CW'(blk_d % NB) * BLK_SZ;
    y_d = mby_d * MB_SZ + CW'(blk_d / NB) * BLK_SZ;
  end

  always_comb begin
    busy       = (state_q == RUN);
    x          = x_q;
    y          = y_q;
    mb_x       = mbx_q;
    mb_y       = mby_q;
    blk_idx    = blk_q;
    mb_done    = mbd_q;
    frame_done = fd_q;
  end

endmodule

// File: tb/tb_blk_pos_counter.sv
// Scoreboard bench for blk_pos_counter: a linear-macroblock-index model predicts every cycle,
// plus a default-size (352x288) full-frame run.
module tb_blk_pos_counter;

  localparam int FW = 32, FH = 32, MBS = 16, BS = 4, CW = 16;
  localparam int N = MBS / BS, NN = N * N, MBW = FW / MBS, MBH = FH / MBS;

  typedef struct packed {
    logic [CW-1:0] x, y, mbx, mby;
    logic [7:0]    blk;
    logic          busy, mbd, fd;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, start = 1'b0, step = 1'b0, mb_next = 1'b0, mb_back = 1'b0;
  logic [CW-1:0] x, y, mb_x, mb_y;
  logic [7:0] blk_idx;
  logic busy, mb_done, frame_done;

  blk_pos_counter #(.FRAME_W(FW), .FRAME_H(FH), .MB_SIZE(MBS), .BLK_SIZE(BS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .mb_next(mb_next), .mb_back(mb_back),
    .x(x), .y(y), .mb_x(mb_x), .mb_y(mb_y), .blk_idx(blk_idx),
    .busy(busy), .mb_done(mb_done), .frame_done(frame_done));

  logic rst2 = 1'b0, start2 = 1'b0, step2 = 1'b0, nxt2 = 1'b0, bk2 = 1'b0;
  logic [CW-1:0] x2, y2, mbx2, mby2;
  logic [7:0] blk2;
  logic busy2, mbd2, fd2;

  blk_pos_counter dut2 (
    .clk(clk), .rst(rst2), .start(start2), .step(step2), .mb_next(nxt2), .mb_back(bk2),
    .x(x2), .y(y2), .mb_x(mbx2), .mb_y(mby2), .blk_idx(blk2),
    .busy(busy2), .mb_done(mbd2), .frame_done(fd2));

  int checks = 0, errors = 0;
  obs_t expq[$];

  // Reference model: macroblock position as one linear raster index
  bit m_run = 0;
  int m_mb = 0, m_blk = 0;

  function automatic obs_t model(input bit st, stp, nx, bk, r);
    obs_t e;
    bit mbd = 0, fd = 0, lv = 0;
    if (!r) begin
      m_run = 0; m_mb = 0; m_blk = 0;
    end else if (!m_run) begin
      if (st) begin m_run = 1; m_mb = 0; m_blk = 0; end
    end else begin
      if (bk) begin
        if (m_mb % MBW != 0) begin m_mb--; m_blk = 0; end
      end else if (nx) lv = 1;
      else if (stp) begin
        if (m_blk < NN - 1) m_blk++;
        else lv = 1;
      end
      if (lv) begin
        m_blk = 0; mbd = 1; m_mb++;
        if (m_mb == MBW * MBH) begin fd = 1; m_mb = 0; m_run = 0; end
      end
    end
    e.mbx  = CW'(m_mb % MBW);
    e.mby  = CW'(m_mb / MBW);
    e.blk  = 8'(m_blk);
    e.x    = CW'((m_mb % MBW) * MBS + (m_blk % N) * BS);
    e.y    = CW'((m_mb / MBW) * MBS + (m_blk / N) * BS);
    e.busy = m_run; e.mbd = mbd; e.fd = fd;
    return e;
  endfunction

  task automatic cyc(input bit st, stp, nx, bk, r);
    @(negedge clk);
    start = st; step = stp; mb_next = nx; mb_back = bk; rst = r;
    expq.push_back(model(st, stp, nx, bk, r));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 1);
  endtask

  // Monitor: each expectation pushed before an edge is compared just after that edge
  int cyc_no = 0;
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = '{x: x, y: y, mbx: mb_x, mby: mb_y, blk: blk_idx, busy: busy, mbd: mb_done, fd: frame_done};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cyc%0d got x=%0d y=%0d mbx=%0d mby=%0d blk=%0d busy=%b mbd=%b fd=%b exp x=%0d y=%0d mbx=%0d mby=%0d blk=%0d busy=%b mbd=%b fd=%b",
                   cyc_no, a.x, a.y, a.mbx, a.mby, a.blk, a.busy, a.mbd, a.fd,
                   e.x, e.y, e.mbx, e.mby, e.blk, e.busy, e.mbd, e.fd);
        end
      end
    end
  end

  initial begin
    int k, fd_at, maxx, maxy;
    // reset held with step high, then start
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    // sub-block walk across the first macroblock boundary
    repeat (16) cyc(0, 1, 0, 0, 1);
    idle(2);
    // skip and back
    cyc(0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 1);
    repeat (5) cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 1, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    // full frame with step held, then one more step and step in IDLE
    cyc(0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 1);
    repeat (64) cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1); cyc(0, 0, 1, 0, 1); cyc(0, 0, 0, 1, 1);
    // start ignored while running
    cyc(1, 0, 0, 0, 1);
    repeat (3) cyc(0, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1); idle(1);
    // reset mid-walk at mb_x=1, blk_idx=7 with mb_next
    cyc(0, 0, 1, 0, 1);
    repeat (7) cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    idle(2);
    // back-to-back frames: start on the frame_done cycle
    cyc(1, 0, 0, 0, 1);
    repeat (64) cyc(0, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1); cyc(0, 1, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit st, stp, nx, bk, rr;
      r   = $urandom_range(0, 99);
      stp = ($urandom_range(0, 99) < 75);
      nx  = ($urandom_range(0, 99) < 6);
      bk  = ($urandom_range(0, 99) < 6);
      st  = ($urandom_range(0, 99) < 15);
      rr  = !(r < 1);
      cyc(st, stp, nx, bk, rr);
    end
    idle(1);
    @(posedge clk); #2;

    // default-size frame on the second instance
    @(negedge clk); rst2 = 1'b0;
    @(negedge clk); rst2 = 1'b1; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; step2 = 1'b1;
    k = 0; fd_at = -1; maxx = 0; maxy = 0;
    while (k < 7000 && fd_at < 0) begin
      @(posedge clk); #1;
      k++;
      if (int'(x2) > maxx) maxx = int'(x2);
      if (int'(y2) > maxy) maxy = int'(y2);
      if (fd2) fd_at = k;
    end
    step2 = 1'b0;
    checks++;
    if (fd_at != 6336) begin
      errors++;
      $display("FAIL big_frame_done got step %0d exp 6336", fd_at);
    end
    checks++;
    if (maxx != 348) begin
      errors++;
      $display("FAIL big_max_x got %0d exp 348", maxx);
    end
    checks++;
    if (maxy != 284) begin
      errors++;
      $display("FAIL big_max_y got %0d exp 284", maxy);
    end
    checks++;
    if (busy2 !== 1'b0 || mbd2 !== 1'b1 || x2 !== '0 || y2 !== '0) begin
      errors++;
      $display("FAIL big_final got busy=%b mbd=%b x=%0d y=%0d exp busy=0 mbd=1 x=0 y=0", busy2, mbd2, x2, y2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
